// File: rtl/fetch_unit.sv
// MIPS-R2000 IF stage: owns the PC, fetches over req/ack and drives IF/ID; result lands one cycle after ack.
// Stall parks an acked word in a skid register and drops imem_req; redirects during an open request drain it first.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  output logic        fetch_exception
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        valid_q, valid_d;
  logic        exc_q, exc_d;

  logic        redir_ok;
  logic [31:0] pc_plus4;

  // A misaligned target is dropped on the floor; only the exception pulse remains.
  assign redir_ok = redirect && (redirect_pc[1:0] == 2'b00);
  assign exc_d    = redirect && (redirect_pc[1:0] != 2'b00);
  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_ISSUE;
      pc_q         <= RESET_PC;
      pending_pc_q <= 32'h0;
      skid_inst_q  <= 32'h0;
      skid_pc_q    <= 32'h0;
      inst_q       <= 32'h0;
      ifid_pc_q    <= 32'h0;
      valid_q      <= 1'b0;
      exc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_pc_q <= pending_pc_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      inst_q       <= inst_d;
      ifid_pc_q    <= ifid_pc_d;
      valid_q      <= valid_d;
      exc_q        <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ISSUE: begin
        if (imem_ack) begin
          if (!redir_ok && stall) state_d = ST_HOLD;
        end else if (redir_ok) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (imem_ack) state_d = ST_ISSUE;
      ST_HOLD:  if (redir_ok || !stall) state_d = ST_ISSUE;
      default:  state_d = ST_ISSUE;
    endcase
  end

  // pc still names the outstanding request while draining, so the address is pc in both fetch states.
  always_comb begin
    imem_req  = rst_n && (state_q != ST_HOLD);
    imem_addr = pc_q;
  end

  always_comb begin
    pc_d         = pc_q;
    pending_pc_d = pending_pc_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    inst_d       = inst_q;
    ifid_pc_d    = ifid_pc_q;
    valid_d      = valid_q;
    case (state_q)
      ST_ISSUE: begin
        if (imem_ack) begin
          if (redir_ok) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
          end else if (stall) begin
            skid_inst_d = imem_rdata;
            skid_pc_d   = pc_plus4;
            pc_d        = pc_plus4;
          end else begin
            inst_d    = imem_rdata;
            ifid_pc_d = pc_plus4;
            valid_d   = 1'b1;
            pc_d      = pc_plus4;
          end
        end else if (redir_ok) begin
          pending_pc_d = redirect_pc;
          valid_d      = 1'b0;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        valid_d = 1'b0;
        if (redir_ok) pending_pc_d = redirect_pc;
        if (imem_ack) pc_d = redir_ok ? redirect_pc : pending_pc_q;
      end
      ST_HOLD: begin
        if (redir_ok) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (!stall) begin
          inst_d    = skid_inst_q;
          ifid_pc_d = skid_pc_q;
          valid_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign inst_out        = inst_q;
  assign pc_out          = ifid_pc_q;
  assign inst_valid      = valid_q;
  assign fetch_exception = exc_q;

endmodule
